// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction fetch sequencer: memory commands,
// FSM states and the opcode that stops fetching.
package fetch_pkg;

    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_READ = 2'b01
    } mem_cmd_e;

    typedef enum logic [1:0] {
        S_RESET = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_HALT  = 2'b11
    } state_e;

    localparam logic [2:0] HALT_OPCODE = 3'b111;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter register: sync reset to RESET_PC, +1 with wrap on inc,
// branch target on load (load wins over inc).
module pc_counter
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 9,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads memory at pc, loads the IR, starts the
// execute datapath and waits for it. Optional halt opcode via FETCH_HALT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 9,
    parameter int                INSN_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INSN_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [INSN_W-1:0] ir_in,
    output logic              ir_load,
    output logic              exec_start,
    input  logic              exec_done,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    state_e state;
    state_e state_next;
    logic   exec_start_next;
    logic   halt_hit;
    logic   pc_inc;
    logic   pc_load;

`ifdef FETCH_HALT_EN
    assign halt_hit = (mem_rdata[INSN_W-1 -: 3] == HALT_OPCODE);
    assign halted   = (state == S_HALT);
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    assign mem_addr = pc;
    assign ir_in    = mem_rdata;

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .reset  (reset),
        .inc    (pc_inc),
        .load   (pc_load),
        .target (branch_target),
        .pc     (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_RESET;
            exec_start <= 1'b0;
        end else begin
            state      <= state_next;
            exec_start <= exec_start_next;
        end
    end

    always_comb begin
        state_next      = state;
        mem_cmd         = MEM_NONE;
        ir_load         = 1'b0;
        exec_start_next = 1'b0;
        pc_inc          = 1'b0;
        pc_load         = 1'b0;
        case (state)
            S_RESET: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_cmd = MEM_READ;
                // The IR must not capture anything while reset is being applied.
                if (mem_valid && !reset) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    if (halt_hit) begin
                        state_next = S_HALT;
                    end else begin
                        state_next      = S_EXEC;
                        exec_start_next = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    pc_load    = branch_taken;
                    state_next = S_FETCH;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: randomized memory/execute responder with a
// program-order reference model; a monitor checks every IR load and exec_start.
module tb_fetch_unit;

    localparam int ADDR_W = 9;
    localparam int INSN_W = 16;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [INSN_W-1:0] mem_rdata = '0;
    logic              mem_valid = 1'b0;
    logic [INSN_W-1:0] ir_in;
    logic              ir_load;
    logic              exec_start;
    logic              exec_done = 1'b0;
    logic              branch_taken = 1'b0;
    logic [ADDR_W-1:0] branch_target = '0;
    logic [ADDR_W-1:0] pc;
    logic              halted;

    fetch_unit #(.ADDR_W(ADDR_W), .INSN_W(INSN_W), .RESET_PC('0)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_cmd       (mem_cmd),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_valid     (mem_valid),
        .ir_in         (ir_in),
        .ir_load       (ir_load),
        .exec_start    (exec_start),
        .exec_done     (exec_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [INSN_W-1:0] data;
    } exp_t;

    exp_t              exp_q[$];
    logic [INSN_W-1:0] mem [512];
    logic [ADDR_W-1:0] model_pc;
    bit                halt_expect = 1'b0;
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every IR load must match the next instruction in program order,
    // and exec_start must follow each non-halting load by exactly one cycle.
    initial begin
        bit   prev_load = 1'b0;
        bit   prev_halt = 1'b0;
        bit   prev_rst  = 1'b1;
        exp_t e;
        forever begin
            @(negedge clk);
            chk("exec_start", 32'(exec_start), 32'(prev_load && !prev_halt && !prev_rst));
            chk("halted", 32'(halted), 32'(halt_expect));
            if (ir_load) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ir_load: got ir_load=1 addr %0h expected no load", mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("ir_addr", 32'(mem_addr), 32'(e.addr));
                    chk("ir_in", 32'(ir_in), 32'(e.data));
                end
            end
            prev_load = ir_load;
            prev_rst  = reset;
            prev_halt = HALT_EN && (ir_in[INSN_W-1 -: 3] == 3'b111);
        end
    end

    // abort: 0 normal, 1 reset during fetch, 2 reset during execute, 3 halt
    task automatic run_insn(input int lat, input int dly, input bit br,
                            input logic [ADDR_W-1:0] tgt, input int abort);
        int n = 0;
        mem_valid = 1'b0;
        exec_done = 1'b0;
        branch_taken = 1'b0;
        while (mem_cmd != 2'b01 && n < 20) begin
            tick();
            n++;
        end
        chk("fetch_reached", 32'(n < 20), 32'd1);
        chk("fetch_addr", 32'(mem_addr), 32'(model_pc));
        chk("fetch_pc", 32'(pc), 32'(model_pc));
        for (int i = 0; i < lat; i++) begin
            mem_valid = 1'b0;
            mem_rdata = INSN_W'($urandom);
            exec_done = 1'($urandom);
            branch_taken = 1'b1;
            branch_target = ADDR_W'($urandom);
            tick();
            chk("hold_cmd", 32'(mem_cmd), 32'd1);
            chk("hold_addr", 32'(mem_addr), 32'(model_pc));
        end
        if (abort == 1) begin
            reset = 1'b1;
            mem_valid = 1'b1;
            mem_rdata = mem[mem_addr];
            tick();
            reset = 1'b0;
            mem_valid = 1'b1;  // late response must be dropped
            chk("rst_pc", 32'(pc), 32'd0);
            chk("rst_cmd", 32'(mem_cmd), 32'd0);
            chk("rst_start", 32'(exec_start), 32'd0);
            tick();
            mem_valid = 1'b0;
            model_pc = '0;
            return;
        end
        mem_valid = 1'b1;
        mem_rdata = mem[mem_addr];
        exec_done = 1'($urandom);
        branch_taken = 1'b1;
        exp_q.push_back('{addr: model_pc, data: mem[model_pc]});
        tick();
        if (abort == 3) halt_expect = 1'b1;
        mem_valid = 1'b0;
        exec_done = 1'b0;
        branch_taken = 1'b0;
        model_pc = model_pc + 1'b1;
        chk("exec_cmd", 32'(mem_cmd), 32'd0);
        chk("exec_pc", 32'(pc), 32'(model_pc));
        if (abort == 3) begin
            for (int i = 0; i < 8; i++) begin
                mem_valid = 1'($urandom);
                exec_done = 1'($urandom);
                tick();
                chk("halt_cmd", 32'(mem_cmd), 32'd0);
                chk("halt_pc", 32'(pc), 32'(model_pc));
            end
            return;
        end
        if (abort == 2) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk("rst_pc", 32'(pc), 32'd0);
            chk("rst_cmd", 32'(mem_cmd), 32'd0);
            chk("rst_start", 32'(exec_start), 32'd0);
            model_pc = '0;
            return;
        end
        for (int i = 0; i < dly; i++) begin
            mem_valid = 1'($urandom);
            mem_rdata = INSN_W'($urandom);
            tick();
        end
        exec_done = 1'b1;
        branch_taken = br;
        branch_target = tgt;
        mem_valid = 1'($urandom);
        tick();
        if (br) model_pc = tgt;
        exec_done = 1'b0;
        branch_taken = 1'b0;
        mem_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [INSN_W-1:0] w;
        for (int i = 0; i < 512; i++) begin
            w = INSN_W'($urandom);
            if (HALT_EN && w[INSN_W-1 -: 3] == 3'b111) w[INSN_W-1] = 1'b0;
            mem[i] = w;
        end
        mem[0] = 16'hA5C3;
        model_pc = '0;

        // Reset state and release
        reset = 1'b1;
        tick();
        tick();
        chk("reset_pc", 32'(pc), 32'd0);
        chk("reset_cmd", 32'(mem_cmd), 32'd0);
        chk("reset_start", 32'(exec_start), 32'd0);
        reset = 1'b0;
        chk("s_reset_cmd", 32'(mem_cmd), 32'd0);
        tick();
        chk("first_read_cmd", 32'(mem_cmd), 32'd1);
        chk("first_read_addr", 32'(mem_addr), 32'd0);

        run_insn(0, 2, 1'b0, '0, 0);          // A5C3 at addr 0, then addr 1
        run_insn(4, 1, 1'b0, '0, 0);          // 4-cycle memory latency
        run_insn(0, 0, 1'b1, 9'h1FF, 0);      // jump to last address
        run_insn(1, 0, 1'b0, '0, 0);          // 1FF wraps to 000
        run_insn(0, 1, 1'b1, 9'h040, 0);      // branch to 040
        run_insn(2, 0, 1'b1, 9'd5, 0);        // land on 040, branch to 5
        run_insn(0, 1, 1'b0, '0, 0);          // 5 -> 6
        run_insn(0, 0, 1'b0, '0, 0);          // fetch at 6
        run_insn(2, 0, 1'b0, '0, 1);          // reset during fetch
        run_insn(1, 0, 1'b0, '0, 0);          // refetch at 0
        run_insn(0, 2, 1'b0, '0, 2);          // reset during execute
        run_insn(0, 0, 1'b0, '0, 0);          // refetch at 0

        for (int k = 0; k < 150; k++) begin
            run_insn(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) == 0), ADDR_W'($urandom), 0);
        end

        mem[model_pc] = 16'hE000;
        if (HALT_EN) begin
            run_insn(1, 0, 1'b0, '0, 3);
        end else begin
            run_insn(1, 1, 1'b0, '0, 0);
            run_insn(0, 0, 1'b0, '0, 0);
        end

        tick();
        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
